// File: rtl/booth_mult_32_bit_if.sv
// rtl/booth_mult_32_bit_if.sv - start/busy/done request and result bundle for the Booth multiplier
interface booth_mult_32_bit_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] product;
    logic        busy;
    logic        done;

    modport master (
        output start, a, b,
        input  product, busy, done
    );

    modport slave (
        input  start, a, b,
        output product, busy, done
    );
endinterface

// File: rtl/booth_mult_32_bit.sv
// rtl/booth_mult_32_bit.sv - sequential radix-2 Booth multiplier, 32x32 signed to 64-bit product
module adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};
endmodule

module booth_mult_32_bit (
    input  logic                clk,
    input  logic                rst,
    booth_mult_32_bit_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] m;
    logic [31:0] acc;
    logic [31:0] q;
    logic        q_m1;
    logic [5:0]  count;
    logic [63:0] product_r;
    logic        busy_r;
    logic        done_r;

    logic [31:0] bop;
    logic        c_in;
    logic [31:0] sum;
    logic        c_out;
    logic        sign;
    logic [31:0] next_acc;
    logic [31:0] next_q;

    always_comb begin
        bop  = 32'd0;
        c_in = 1'b0;
        case ({q[0], q_m1})
            2'b01: begin
                bop  = m;
                c_in = 1'b0;
            end
            2'b10: begin
                bop  = ~m;
                c_in = 1'b1;
            end
            default: begin
                bop  = 32'd0;
                c_in = 1'b0;
            end
        endcase
    end

    adder_32_bit u_adder (
        .a     (acc),
        .b     (bop),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out)
    );

    // Bit 32 of the true 33-bit result; sum[31] alone overflows when m = 0x80000000.
    assign sign     = acc[31] ^ bop[31] ^ c_out;
    assign next_acc = {sign, sum[31:1]};
    assign next_q   = {sum[0], q[31:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            m         <= 32'd0;
            acc       <= 32'd0;
            q         <= 32'd0;
            q_m1      <= 1'b0;
            count     <= 6'd0;
            product_r <= 64'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        m      <= bus.a;
                        acc    <= 32'd0;
                        q      <= bus.b;
                        q_m1   <= 1'b0;
                        count  <= 6'd0;
                        busy_r <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= next_acc;
                    q     <= next_q;
                    q_m1  <= q[0];
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        product_r <= {next_acc, next_q};
                        done_r    <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.product = product_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
endmodule
